// File: rtl/serial_key_receiver.sv
// serial_key_receiver
//   Receives 8N1 serial bytes, queues them in a small circular FIFO and
//   presents the oldest byte through an IRQ/IACK/IEND interrupt handshake.
//
// Parameters
//   CLKS_PER_BIT : CLK cycles per serial bit
//   FIFO_DEPTH   : queued bytes (power of two, >= 2)
// Ports
//   CLK           in   system clock, rising edge
//   RESET_N       in   asynchronous active-low reset
//   IN_SERIAL_RX  in   asynchronous serial line, idles high
//   OUT_BUFFER    out  [7:0] FIFO head, stable from IRQ through IEND
//   OUT_IRQ       out  FIFO non-empty and no service in progress
//   IN_IACK       in   consumer accepts the interrupt (pulse)
//   IN_IEND       in   consumer finished, pops the head (pulse)
//   OUT_OVERRUN   out  sticky: a byte was dropped on a full FIFO
//   OUT_FRAME_ERR out  one-cycle pulse: stop bit sampled low
module serial_key_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       IN_SERIAL_RX,
  output logic [7:0] OUT_BUFFER,
  output logic       OUT_IRQ,
  input  logic       IN_IACK,
  input  logic       IN_IEND,
  output logic       OUT_OVERRUN,
  output logic       OUT_FRAME_ERR
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CLK_W = $clog2(CLKS_PER_BIT);

  localparam logic [CLK_W-1:0] HALF_LAST = CLK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CLK_W-1:0] FULL_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_t;

  // ---------------------------------------------------------------- RX path
  logic             rxMeta;
  logic             rxSync;
  rxState_t         rxState;
  logic [CLK_W-1:0] clkCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       shiftReg;
  logic             pushValid;   // byte in shiftReg is ready to be queued

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rxMeta        <= 1'b1;
      rxSync        <= 1'b1;
      rxState       <= IDLE;
      clkCnt        <= '0;
      bitIdx        <= '0;
      shiftReg      <= '0;
      pushValid     <= 1'b0;
      OUT_FRAME_ERR <= 1'b0;
    end else begin
      rxMeta        <= IN_SERIAL_RX;
      rxSync        <= rxMeta;
      pushValid     <= 1'b0;
      OUT_FRAME_ERR <= 1'b0;
      case (rxState)
        IDLE: begin
          if (!rxSync) begin
            rxState <= START;
            clkCnt  <= '0;
            bitIdx  <= '0;
          end
        end
        START: begin
          // Mid-bit check: a line that is high again was only a glitch.
          if (clkCnt == HALF_LAST) begin
            clkCnt  <= '0;
            rxState <= rxSync ? IDLE : DATA;
          end else begin
            clkCnt <= clkCnt + CLK_W'(1);
          end
        end
        DATA: begin
          if (clkCnt == FULL_LAST) begin
            clkCnt   <= '0;
            shiftReg <= {rxSync, shiftReg[7:1]};  // LSB arrives first
            bitIdx   <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) rxState <= STOP;
          end else begin
            clkCnt <= clkCnt + CLK_W'(1);
          end
        end
        STOP: begin
          if (clkCnt == FULL_LAST) begin
            clkCnt  <= '0;
            rxState <= IDLE;
            if (rxSync) pushValid     <= 1'b1;
            else        OUT_FRAME_ERR <= 1'b1;
          end else begin
            clkCnt <= clkCnt + CLK_W'(1);
          end
        end
        default: rxState <= IDLE;
      endcase
    end
  end

  // ------------------------------------------------------- FIFO + handshake
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             inService;

  logic             popNow;
  logic             iackAccept;
  logic             pushOk;
  logic             dropNow;
  logic [PTR_W-1:0] rdPtrNext;
  logic [CNT_W-1:0] countNext;
  logic             inServiceNext;
  logic [7:0]       headNext;

  always_comb begin
    popNow     = IN_IEND && inService;
    // IACK counts only alone; with a simultaneous IEND it is ignored.
    iackAccept = IN_IACK && !IN_IEND && OUT_IRQ;
    // A pop in the same cycle frees the slot a full FIFO needs.
    pushOk     = pushValid && ((count != DEPTH_C) || popNow);
    dropNow    = pushValid && !pushOk;
    rdPtrNext  = rdPtr + PTR_W'(popNow);
    countNext  = count + CNT_W'(pushOk) - CNT_W'(popNow);

    inServiceNext = inService;
    if (popNow)          inServiceNext = 1'b0;
    else if (iackAccept) inServiceNext = 1'b1;

    // Bypass: the incoming byte becomes the head when it lands in the slot
    // the read pointer is about to point at (FIFO otherwise empty).
    if (pushOk && (wrPtr == rdPtrNext)) headNext = shiftReg;
    else                                headNext = mem[rdPtrNext];
  end

  always_ff @(posedge CLK) begin
    if (pushOk) mem[wrPtr] <= shiftReg;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      inService   <= 1'b0;
      OUT_IRQ     <= 1'b0;
      OUT_BUFFER  <= 8'h00;
      OUT_OVERRUN <= 1'b0;
    end else begin
      wrPtr     <= wrPtr + PTR_W'(pushOk);
      rdPtr     <= rdPtrNext;
      count     <= countNext;
      inService <= inServiceNext;
      OUT_IRQ   <= (countNext != '0) && !inServiceNext;
      if (countNext != '0) OUT_BUFFER <= headNext;
      if (dropNow) OUT_OVERRUN <= 1'b1;
    end
  end

endmodule

// File: doc/serial_key_receiver.md
# serial_key_receiver

Receives 8N1 serial bytes on the board RX pin and queues them in a small FIFO. It presents the oldest byte to the frame-copy controller through the same IRQ/IACK/IEND interrupt handshake that the system timer uses. It sits directly upstream of the controller's key-command states, which branch on ASCII '1'/'2' to select a frame.

## Interface
- CLKS_PER_BIT, default 868: CLK cycles per serial bit (100 MHz / 115200).
- FIFO_DEPTH, default 4: queued bytes; power of two, at least 2.
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IN_SERIAL_RX  in  1  asynchronous serial line; idles high.
- OUT_BUFFER  out  8  oldest queued byte (FIFO head); stable from IRQ assertion through IEND.
- OUT_IRQ  out  1  high when FIFO non-empty and no service in progress.
- IN_IACK  in  1  one-cycle pulse; consumer accepts the interrupt.
- IN_IEND  in  1  one-cycle pulse; consumer finished; pops the head.
- OUT_OVERRUN  out  1  sticky; a received byte was dropped because the FIFO was full.
- OUT_FRAME_ERR  out  1  one-cycle pulse; stop bit sampled low, byte discarded.

## Operation
- RX path
  - Two-flop synchronizer on IN_SERIAL_RX; all receiver logic uses the synchronized bit.
  - Receiver states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized low level -> START, with the bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample the line.
    - Low -> DATA.
    - High -> IDLE (glitch; nothing reported).
  - DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first, shifted into a byte register; then -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - High -> push the byte.
    - Low -> pulse OUT_FRAME_ERR, discard the byte.
    - Either way -> IDLE in the same cycle, so a new start bit may be detected on the next cycle.
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth, plus a count of width log2(FIFO_DEPTH)+1.
  - Push when full: byte dropped, OUT_OVERRUN set to 1; FIFO unchanged.
  - Push and pop in the same cycle: both take effect, count unchanged. Push with the FIFO full and a pop in the same cycle succeeds.
- Handshake: in_service flag.
  - OUT_IRQ = (count != 0) && !in_service, registered.
  - IN_IACK while OUT_IRQ=1 -> in_service=1. IN_IACK while OUT_IRQ=0 is ignored.
  - IN_IEND while in_service=1 -> pop head, in_service=0. IN_IEND otherwise is ignored.
  - IN_IACK and IN_IEND together: IEND takes precedence if in_service; otherwise both are ignored.
- OUT_BUFFER is registered and always equals mem[rd_ptr] when count != 0. It holds its last value when the FIFO is empty.
- Reset (async, any state, mid-byte included):
  - Receiver -> IDLE.
  - FIFO emptied; pointers and count cleared.
  - in_service=0.
  - OUT_BUFFER=8'h00, OUT_IRQ=0, OUT_OVERRUN=0, OUT_FRAME_ERR=0.
  - A partially received byte is lost.

## Timing
- Synchronizer latency: 2 cycles. The start edge is detected in the third cycle after the pin falls.
- Sample points relative to detection:
  - Start bit: CLKS_PER_BIT/2.
  - Data bit k (k = 0..7): CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
  - Stop bit: CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
- Push occurs in the cycle after the stop sample.
  - OUT_BUFFER valid and OUT_IRQ high 1 cycle after the push if the FIFO was empty and not in service.
- IN_IACK at cycle t -> OUT_IRQ low at t+1.
- IN_IEND at cycle t:
  - Pop at t; new head on OUT_BUFFER at t+1.
  - OUT_IRQ re-asserts at t+1 if count after the pop is non-zero.
- OUT_OVERRUN rises the cycle after the dropped push and stays high until reset.
- OUT_FRAME_ERR is high for exactly the cycle after the stop sample.

## Test plan
(CLKS_PER_BIT=16, FIFO_DEPTH=4 for all scenarios.)
- Single byte: send 8'h31 at 16 cycles/bit -> OUT_IRQ rises 1 cycle after the push with OUT_BUFFER=8'h31. IACK -> OUT_IRQ=0 next cycle. IEND -> OUT_IRQ stays 0 and FIFO empty.
- Burst of 8'h31, 8'h32, 8'h41 back-to-back, service each with IACK, then IEND 3 cycles later -> OUT_BUFFER reads 31, 32, 41 in order. OUT_IRQ re-asserts the cycle after each IEND except the last.
- Overrun: send 5 bytes 8'h01..8'h05 with no service -> OUT_OVERRUN=1 after the fifth stop bit. Draining yields 01, 02, 03, 04 only.
- Framing: send 8'h55 with the stop bit driven low -> OUT_FRAME_ERR high one cycle, OUT_IRQ stays 0, FIFO count 0. A following valid 8'hAA is received correctly.
- Glitch and handshake misuse:
  - 4-cycle low pulse on RX -> no byte, no error.
  - IACK/IEND pulses with an empty FIFO -> ignored; a subsequent byte still raises OUT_IRQ normally.
- Reset mid-byte: assert RESET_N low during data bit 4 of 8'h31 -> all outputs 0 immediately. After release, a fresh 8'h32 is received alone with OUT_BUFFER=8'h32.
